seq_code_checker: RTL and testbench

//  Consumer stage for the 3-bit sequencer output. Samples each code on a valid strobe
//  and checks it against the fixed 6-code cycle 000->001->011->101->111->010->000.

---
 rtl/seq_code_checker_if.sv | 22 ++
 rtl/seq_code_checker.sv | 162 ++++++++++++++++
 tb/tb_seq_code_checker.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_code_checker_if.sv
// Bundle of the sequencer-code stream into the checker and the checker's status outputs.
interface seq_code_checker_if #(
    parameter int unsigned CNT_W = 8
);
    logic             code_valid;
    logic [2:0]       code;
    logic             cnt_clr;
    logic             locked;
    logic             err_pulse;
    logic             cycle_pulse;
    logic [CNT_W-1:0] err_count;

    modport master (
        output code_valid, code, cnt_clr,
        input  locked, err_pulse, cycle_pulse, err_count
    );

    modport slave (
        input  code_valid, code, cnt_clr,
        output locked, err_pulse, cycle_pulse, err_count
    );
endinterface

// File: rtl/seq_code_checker.sv
// Checks a sampled 3-bit sequencer code stream against the 6-code cycle,
// tracks lock, flags mismatches and counts them with saturation.
module seq_code_checker #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned LOCK_N   = 6,
    parameter int unsigned UNLOCK_N = 2
) (
    input logic               clk,
    input logic               clr_n,
    seq_code_checker_if.slave bus
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_SLIP   = 2'd3;

    localparam logic [3:0] LOCK_TGT   = 4'(LOCK_N);
    localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_N);

    logic [1:0]       state, state_nx;
    logic [2:0]       prev;
    logic [3:0]       run_cnt, run_cnt_nx;
    logic [3:0]       miss_cnt, miss_cnt_nx;
    logic             locked_q, locked_nx;
    logic             err_q, err_nx;
    logic             cyc_q, cyc_nx;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_inc;

    function automatic logic is_legal(input logic [2:0] c);
        return (c != 3'b100) && (c != 3'b110);
    endfunction

    function automatic logic [2:0] next_code(input logic [2:0] c);
        logic [2:0] n;
        case (c)
            3'b000:  n = 3'b001;
            3'b001:  n = 3'b011;
            3'b011:  n = 3'b101;
            3'b101:  n = 3'b111;
            3'b111:  n = 3'b010;
            3'b010:  n = 3'b000;
            default: n = 3'b000;
        endcase
        return n;
    endfunction

    logic code_legal;
    logic match;

    // An illegal anchor has no successor, so nothing can match it.
    assign code_legal = is_legal(bus.code);
    assign match      = is_legal(prev) && (bus.code == next_code(prev));

    always_comb begin
        state_nx    = state;
        run_cnt_nx  = run_cnt;
        miss_cnt_nx = miss_cnt;
        locked_nx   = locked_q;
        err_nx      = 1'b0;
        cyc_nx      = 1'b0;
        cnt_inc     = 1'b0;

        if (bus.code_valid) begin
            case (state)
                ST_HUNT: begin
                    if (code_legal) begin
                        state_nx   = ST_SYNC;
                        run_cnt_nx = '0;
                    end
                end

                ST_SYNC: begin
                    if (match) begin
                        run_cnt_nx = run_cnt + 4'd1;
                        if (run_cnt + 4'd1 == LOCK_TGT) begin
                            state_nx    = ST_LOCKED;
                            locked_nx   = 1'b1;
                            miss_cnt_nx = '0;
                        end
                    end else if (code_legal) begin
                        run_cnt_nx = '0;
                    end else begin
                        state_nx = ST_HUNT;
                    end
                end

                ST_LOCKED: begin
                    if (match) begin
                        cyc_nx = (bus.code == 3'b000);
                    end else begin
                        err_nx  = 1'b1;
                        cnt_inc = 1'b1;
                        if (UNLOCK_TGT == 4'd1) begin
                            state_nx    = ST_HUNT;
                            locked_nx   = 1'b0;
                            run_cnt_nx  = '0;
                            miss_cnt_nx = '0;
                        end else begin
                            state_nx    = ST_SLIP;
                            miss_cnt_nx = 4'd1;
                        end
                    end
                end

                default: begin
                    if (match) begin
                        state_nx    = ST_LOCKED;
                        miss_cnt_nx = '0;
                        cyc_nx      = (bus.code == 3'b000);
                    end else begin
                        err_nx      = 1'b1;
                        cnt_inc     = 1'b1;
                        miss_cnt_nx = miss_cnt + 4'd1;
                        if (miss_cnt + 4'd1 == UNLOCK_TGT) begin
                            state_nx    = ST_HUNT;
                            locked_nx   = 1'b0;
                            run_cnt_nx  = '0;
                            miss_cnt_nx = '0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state    <= ST_HUNT;
            prev     <= '0;
            run_cnt  <= '0;
            miss_cnt <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            cyc_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state    <= state_nx;
            run_cnt  <= run_cnt_nx;
            miss_cnt <= miss_cnt_nx;
            locked_q <= locked_nx;
            err_q    <= err_nx;
            cyc_q    <= cyc_nx;
            if (bus.code_valid) begin
                prev <= bus.code;
            end
            // Clear beats a coincident increment; increment saturates at all-ones.
            if (bus.cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.locked      = locked_q;
    assign bus.err_pulse   = err_q;
    assign bus.cycle_pulse = cyc_q;
    assign bus.err_count   = cnt_q;

endmodule

// File: tb/tb_seq_code_checker.sv
// Self-checking bench for seq_code_checker: cycle-by-cycle comparison against a
// behavioural model, plus directed scenarios with hand-computed expectations.
module tb_seq_code_checker;

    logic clk = 1'b0;
    logic clr_n;

    always #5 clk = ~clk;

    seq_code_checker_if #(.CNT_W(8)) bus ();

    seq_code_checker #(
        .CNT_W   (8),
        .LOCK_N  (6),
        .UNLOCK_N(2)
    ) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;

    // Sequence order; position in this table defines the successor relation.
    int seq_tab [6] = '{0, 1, 3, 5, 7, 2};

    function automatic int pos_of(input int c);
        for (int i = 0; i < 6; i++) if (seq_tab[i] == c) return i;
        return -1;
    endfunction

    function automatic logic [2:0] succ(input logic [2:0] c);
        int p;
        p = pos_of(int'(c));
        if (p < 0) return 3'b000;
        return 3'(seq_tab[(p + 1) % 6]);
    endfunction

    // Model: lock status described as a mode with a streak and a miss tally.
    int  m_mode;   // 0 searching, 1 building streak, 2 locked clean, 3 locked after miss
    int  m_streak;
    int  m_miss;
    int  m_prev;
    int  m_cnt;
    bit  m_err;
    bit  m_cyc;

    task automatic model_reset();
        m_mode = 0; m_streak = 0; m_miss = 0; m_prev = 0;
        m_cnt = 0; m_err = 0; m_cyc = 0;
    endtask

    task automatic model_step(input bit rn, input bit v, input int c, input bit clr);
        bit legal, good, bump;
        if (!rn) begin
            model_reset();
            return;
        end
        m_err = 0; m_cyc = 0; bump = 0;
        if (v) begin
            legal = pos_of(c) >= 0;
            good  = (pos_of(m_prev) >= 0) && legal && (pos_of(c) == (pos_of(m_prev) + 1) % 6);
            if (m_mode == 0) begin
                if (legal) begin m_mode = 1; m_streak = 0; end
            end else if (m_mode == 1) begin
                if (good) begin
                    m_streak++;
                    if (m_streak == 6) m_mode = 2;
                end else if (legal) m_streak = 0;
                else m_mode = 0;
            end else begin
                if (good) begin
                    m_mode = 2; m_miss = 0; m_cyc = (c == 0);
                end else begin
                    m_err = 1; bump = 1;
                    m_miss = (m_mode == 2) ? 1 : m_miss + 1;
                    m_mode = 3;
                    if (m_miss == 2) begin m_mode = 0; m_miss = 0; m_streak = 0; end
                end
            end
            m_prev = c;
        end
        if (clr) m_cnt = 0;
        else if (bump && m_cnt < 255) m_cnt++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: update the model from the sampled inputs, check after the edge.
    initial begin
        bit rn, v, clr;
        int c;
        forever begin
            @(posedge clk);
            rn = clr_n; v = bus.code_valid; c = int'(bus.code); clr = bus.cnt_clr;
            model_step(rn, v, c, clr);
            #1;
            if (armed) begin
                check("cmp_locked", int'(bus.locked), int'(m_mode >= 2));
                check("cmp_err_pulse", int'(bus.err_pulse), int'(m_err));
                check("cmp_cycle_pulse", int'(bus.cycle_pulse), int'(m_cyc));
                check("cmp_err_count", int'(bus.err_count), m_cnt);
            end
        end
    end

    logic [2:0] p;

    task automatic step(input bit v, input logic [2:0] c, input bit clr, input bit rn);
        bus.code_valid = v;
        bus.code       = c;
        bus.cnt_clr    = clr;
        clr_n          = rn;
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [2:0] c);
        step(1'b1, c, 1'b0, 1'b1);
    endtask

    // Legal anchor followed by six correct steps, ending on 000.
    task automatic run_to_lock();
        send(3'b000);
        for (int i = 0; i < 6; i++) send(succ(int'(i == 0) ? 3'b000 : bus.code));
    endtask

    initial begin
        bus.code_valid = 1'b0;
        bus.code       = 3'b000;
        bus.cnt_clr    = 1'b0;
        clr_n          = 1'b0;
        @(posedge clk);
        #2;
        armed = 1'b1;
        step(1'b0, 3'b000, 1'b0, 1'b0);
        check("reset_locked", int'(bus.locked), 0);
        check("reset_count", int'(bus.err_count), 0);

        // Lock acquisition; the first wrap arrives before lock so no cycle pulse.
        send(3'b000); send(3'b001); send(3'b011); send(3'b101); send(3'b111); send(3'b010);
        check("t1_not_yet", int'(bus.locked), 0);
        send(3'b000);
        check("t1_locked", int'(bus.locked), 1);
        check("t1_no_cyc", int'(bus.cycle_pulse), 0);
        send(3'b001); send(3'b011); send(3'b101); send(3'b111); send(3'b010); send(3'b000);
        check("t1_cyc", int'(bus.cycle_pulse), 1);

        // Single skipped step while locked, then resume from the received code.
        send(3'b001);
        send(3'b101);
        check("t2_err", int'(bus.err_pulse), 1);
        check("t2_cnt", int'(bus.err_count), 1);
        check("t2_locked", int'(bus.locked), 1);
        send(3'b111);
        check("t2_err_gone", int'(bus.err_pulse), 0);
        send(3'b010); send(3'b000);
        check("t2_cyc", int'(bus.cycle_pulse), 1);

        // Two consecutive mismatches drop lock; count starts from a clear.
        step(1'b0, 3'b000, 1'b1, 1'b1);
        check("t3_clr", int'(bus.err_count), 0);
        send(3'b100);
        check("t3_slip_locked", int'(bus.locked), 1);
        send(3'b100);
        check("t3_cnt", int'(bus.err_count), 2);
        check("t3_unlock", int'(bus.locked), 0);
        send(3'b000); send(3'b001); send(3'b011); send(3'b101); send(3'b111); send(3'b010);
        check("t3_relock_wait", int'(bus.locked), 0);
        send(3'b000);
        check("t3_relock", int'(bus.locked), 1);

        // Gapped strobes with the code wandering while invalid.
        step(1'b0, 3'b000, 1'b1, 1'b0);
        p = 3'b000;
        for (int i = 0; i < 7; i++) begin
            send(p);
            if (i == 5) check("t4_not_yet", int'(bus.locked), 0);
            if (i == 6) check("t4_locked", int'(bus.locked), 1);
            for (int g = 0; g < 3; g++) step(1'b0, 3'($urandom_range(0, 7)), 1'b0, 1'b1);
            p = succ(p);
        end

        // Saturation: repeat-then-resume pairs each add one error without losing lock.
        p = 3'b000;
        for (int i = 0; i < 255; i++) begin
            send(p);
            p = succ(p);
            send(p);
        end
        check("t5_255", int'(bus.err_count), 255);
        send(p);
        check("t5_sat", int'(bus.err_count), 255);
        check("t5_err", int'(bus.err_pulse), 1);
        step(1'b1, p, 1'b1, 1'b1);
        check("t5_clr_wins", int'(bus.err_count), 0);

        // Reset while locked with a valid sample present.
        send(3'b000); send(3'b001); send(3'b011); send(3'b101); send(3'b111); send(3'b010); send(3'b000);
        send(3'b011);
        check("t6_pre_cnt", int'(bus.err_count), 1);
        step(1'b1, 3'b100, 1'b0, 1'b0);
        check("t6_locked", int'(bus.locked), 0);
        check("t6_cnt", int'(bus.err_count), 0);
        check("t6_err", int'(bus.err_pulse), 0);
        check("t6_cyc", int'(bus.cycle_pulse), 0);
        send(3'b000); send(3'b001); send(3'b011); send(3'b101); send(3'b111); send(3'b010); send(3'b000);
        check("t6_relock", int'(bus.locked), 1);

        // Random traffic: mostly in-sequence codes with slips, gaps, clears and rare resets.
        p = 3'b000;
        for (int i = 0; i < 4000; i++) begin
            bit v, clr, rn;
            logic [2:0] c;
            v   = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 99) == 0);
            rn  = ($urandom_range(0, 299) != 0);
            if (!v) c = 3'($urandom_range(0, 7));
            else if ($urandom_range(0, 9) < 8) c = succ(p);
            else c = 3'($urandom_range(0, 7));
            if (v) p = c;
            step(v, c, clr, rn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
